// File: rtl/ps2_key_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ps2_key_tracker                                               |
// | Purpose  : Parses PS/2 make / break (F0) / extended (E0) scan-code       |
// |            sequences and keeps a last-note-priority stack of held keys.  |
// |            The most recently pressed held key is presented on key_code.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ps2_key_tracker #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic [7:0] key_code,
    output logic       enable,
    output logic [2:0] held_count,
    output logic       key_press,
    output logic       key_release
);

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_BREAK     = 2'd1;
    localparam logic [1:0] c_ST_EXT       = 2'd2;
    localparam logic [1:0] c_ST_EXT_BREAK = 2'd3;

    localparam logic [7:0] c_BYTE_BREAK = 8'hF0;
    localparam logic [7:0] c_BYTE_EXT   = 8'hE0;
    localparam logic [2:0] c_DEPTH      = 3'(DEPTH);

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [7:0] r_stack      [DEPTH];
    logic [7:0] w_stack_next [DEPTH];
    logic [2:0] r_count;
    logic [2:0] w_count_next;
    logic [7:0] r_key_code;
    logic [7:0] w_key_next;
    logic       r_enable;
    logic       r_press;
    logic       r_release;
    logic       w_press;
    logic       w_release;
    logic       w_ignored;
    logic       w_is_make;
    logic       w_is_break;
    logic       w_hit;
    logic [2:0] w_hit_idx;

    // Parser state register; reset drops any pending F0/E0 prefix.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Parser next state and classification of the current byte.
    always_comb begin
        w_state_next = r_state;
        w_is_make    = 1'b0;
        w_is_break   = 1'b0;
        w_ignored    = (byte_data inside {8'hAA, 8'hFA, 8'hFE, 8'hEE,
                                          8'hFC, 8'h00, 8'hFF});
        if (byte_valid) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (byte_data == c_BYTE_BREAK) begin
                        w_state_next = c_ST_BREAK;
                    end else if (byte_data == c_BYTE_EXT) begin
                        w_state_next = c_ST_EXT;
                    end else if (!w_ignored) begin
                        w_is_make = 1'b1;
                    end
                end
                c_ST_BREAK: begin
                    w_is_break   = 1'b1;
                    w_state_next = c_ST_IDLE;
                end
                c_ST_EXT: begin
                    w_state_next = (byte_data == c_BYTE_BREAK) ? c_ST_EXT_BREAK
                                                               : c_ST_IDLE;
                end
                default: begin
                    w_state_next = c_ST_IDLE;
                end
            endcase
        end
    end

    // Membership search over live entries only; keys are unique in the stack.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = 3'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((3'(i) < r_count) && (r_stack[i] == byte_data)) begin
                w_hit     = 1'b1;
                w_hit_idx = 3'(i);
            end
        end
    end

    // Stack push / overflow shift / removal, and the resulting top-of-stack.
    always_comb begin
        w_stack_next = r_stack;
        w_count_next = r_count;
        w_press      = 1'b0;
        w_release    = 1'b0;
        if (w_is_make && !w_hit) begin
            w_press = 1'b1;
            if (r_count == c_DEPTH) begin
                // Full: oldest key at entry 0 is dropped silently.
                for (int i = 0; i < DEPTH - 1; i++) begin
                    w_stack_next[i] = r_stack[i+1];
                end
                w_stack_next[DEPTH-1] = byte_data;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (3'(i) == r_count) begin
                        w_stack_next[i] = byte_data;
                    end
                end
                w_count_next = r_count + 3'd1;
            end
        end else if (w_is_break && w_hit) begin
            w_release = 1'b1;
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (3'(i) >= w_hit_idx) begin
                    w_stack_next[i] = r_stack[i+1];
                end
            end
            w_count_next = r_count - 3'd1;
        end

        w_key_next = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            if ((3'(i) + 3'd1) == w_count_next) begin
                w_key_next = w_stack_next[i];
            end
        end
    end

    // Registered stack, count and all outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stack[i] <= 8'h00;
            end
            r_count    <= 3'd0;
            r_key_code <= 8'h00;
            r_enable   <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
        end else begin
            r_stack    <= w_stack_next;
            r_count    <= w_count_next;
            r_key_code <= w_key_next;
            r_enable   <= (w_count_next != 3'd0);
            r_press    <= w_press;
            r_release  <= w_release;
        end
    end

    assign key_code    = r_key_code;
    assign enable      = r_enable;
    assign held_count  = r_count;
    assign key_press   = r_press;
    assign key_release = r_release;

endmodule
`default_nettype wire
